dac_spi_master: RTL
===================

Name: dac_spi_master

Overview:
- Synthesizable SPI initiator that drives the dual-channel serial DAC.
- Accepts a channel select and a 16-bit sample over a valid/ready handshake.
- Serializes one 24-bit frame per sample, MSB first: 8-bit control byte, then 16-bit data.
- Sits between the sample-generation logic and the DAC pins (SCK, SDI, CS_).

Parameters:
- CLK_DIV, 4: clk cycles per SCK half-period; legal range 1..255. SCK frequency is clk/(2*CLK_DIV).

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset_  input  1  asynchronous, active-low reset
- start  input  1  request to send one frame; qualified by ready
- chan  input  1  DAC channel: 0 = A, 1 = B
- data  input  16  sample to send
- ready  output  1  high when idle and able to accept start
- done  output  1  one-cycle pulse when a frame completes (same cycle CS_ rises)
- SCK  output  1  serial clock to DAC; idles low
- SDO  output  1  serial data to the DAC SDI pin
- CS_  output  1  active-low chip select to DAC

Behaviour:
- Reset and control: one clock; reset is asynchronous and active-low (reset_).
- Reset values: SCK=0, CS_=1, SDO=0, ready=1, done=0; FSM in IDLE; shift register and counters cleared.
- All outputs are registered. No combinational path from inputs to outputs.
- Frame word: {4'b0000, 3'b000, chan, data_tx}. Control bits [3:0] = chan selects A/B; upper control bits are always 0.
- data_tx is data, except as modified by the optional feature.
- Acceptance: start && ready sampled at edge 0 captures chan/data into a 24-bit shift register. ready drops the next cycle.
- start while ready=0 is ignored; no queuing.
- FSM states: IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP.
- IDLE -> SETUP on acceptance.
  - Cycle 1: CS_=0, SDO=frame[23].
- SETUP holds CLK_DIV cycles, then SCK rises (first rise at cycle 1+CLK_DIV). Go to SCK_HI.
- SCK_HI holds CLK_DIV cycles, then SCK falls.
  - On the same edge, SDO advances to the next bit, MSB first.
  - The bit counter increments; go to SCK_LO.
- SCK_LO holds CLK_DIV cycles, then SCK rises. Go to SCK_HI, unless 24 bits are sent, then go to HOLD.
- Edge timing: rise k (k=0..23) at cycle 1+CLK_DIV*(1+2k). The DAC samples SDO on each rise. SDO is stable for >= CLK_DIV cycles on both sides of each rise.
- HOLD: after the 24th fall, SDO=0 and SCK stays 0 for CLK_DIV cycles. Then CS_=1 and done=1 for one cycle (cycle 1+50*CLK_DIV). Go to GAP.
- GAP: CS_ held high for CLK_DIV cycles (minimum deselect time). Then ready=1 at cycle 1+51*CLK_DIV and return to IDLE.
- Back-to-back start: the earliest next acceptance is the first cycle ready=1. CS_ is never low for two frames without the GAP.
- Exactly 24 SCK rising edges occur per CS_ low window. SCK is always 0 when CS_ changes.
- Reset mid-frame: outputs return to reset values immediately (CS_=1, SCK=0). The partial frame is abandoned and done is not pulsed.
- Counters: half-period counter is 8 bits; bit counter is 5 bits, range 0..24. No wrap occurs within legal parameters.

Optional Feature:
- Macro: DAC_SPI_TWOS_COMP_EN.
- Defined: data is treated as two's complement. data_tx = {~data[15], data[14:0]}, converting to the DAC's offset-binary code.
- Undefined: data_tx = data, sent unmodified.
- Control byte and timing are identical in both builds.

Test Plan:
- Reset check: hold reset_=0 -> SCK=0, CS_=1, SDO=0, ready=1, done=0. Release -> all outputs unchanged until start.
- Channel A frame: CLK_DIV=4, start with chan=0, data=16'h1234, feature off.
  - SDO sampled on SCK rises = 24'h00_1234.
  - CS_ low from cycle 1 through 200; done at 201; ready at 205.
  - DAC model prints 9234.
- Channel B frame: chan=1, data=16'hFFFF -> bits 24'h01_FFFF; exactly 24 SCK rises; DAC model prints 7fff.
- Feature on: DAC_SPI_TWOS_COMP_EN defined, chan=0, data=16'h8000 -> bits 24'h00_0000; DAC model prints 8000.
- Back-to-back and busy handling: start held high continuously with CLK_DIV=1.
  - Frames separated by CS_ high for >= 1 cycle.
  - start during busy is ignored.
  - Each frame's done is a single cycle.
- Abort: assert reset_ low at the 10th SCK rise -> CS_=1 and SCK=0 within the same cycle, no done, ready=1 after release.

Source files
------------

// File: rtl/dac_spi_master.sv
// dac_spi_master
//   SPI initiator for the dual-channel serial DAC. Each accepted sample is
//   sent as one 24-bit frame, MSB first: an 8-bit control byte
//   {4'b0000, 3'b000, chan} followed by the 16-bit sample. SCK idles low and
//   the DAC samples SDO on SCK rising edges. Every output is registered.
//
//   Optional build macro: DAC_SPI_TWOS_COMP_EN
//     defined   - data is two's complement; the MSB is inverted to produce
//                 the DAC's offset-binary code.
//     undefined - data is sent unmodified.
//
// Parameters
//   CLK_DIV  clk cycles per SCK half-period (1..255); SCK = clk/(2*CLK_DIV)
//
// Ports
//   clk     in   system clock, rising edge
//   reset_  in   asynchronous active-low reset
//   start   in   send request, taken only while ready is high
//   chan    in   DAC channel (0 = A, 1 = B)
//   data    in   16-bit sample
//   ready   out  idle and able to accept start
//   done    out  one-cycle pulse in the cycle CS_ rises at frame end
//   SCK     out  serial clock to the DAC
//   SDO     out  serial data to the DAC SDI pin
//   CS_     out  active-low chip select
module dac_spi_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        start,
    input  logic        chan,
    input  logic [15:0] data,
    output logic        ready,
    output logic        done,
    output logic        SCK,
    output logic        SDO,
    output logic        CS_
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] HP_LAST    = 8'(CLK_DIV - 1);
    localparam logic [4:0] FRAME_BITS = 5'd24;

    state_t      state_q,   state_d;
    logic [7:0]  hp_cnt_q,  hp_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [23:0] shift_q,   shift_d;
    logic        sck_q,     sck_d;
    logic        sdo_q,     sdo_d;
    logic        cs_n_q,    cs_n_d;
    logic        ready_q,   ready_d;
    logic        done_q,    done_d;

    logic [15:0] data_tx;
    logic [23:0] frame;
    logic        hp_last;

`ifdef DAC_SPI_TWOS_COMP_EN
    assign data_tx = {~data[15], data[14:0]};
`else
    assign data_tx = data;
`endif

    assign frame   = {4'b0000, 3'b000, chan, data_tx};
    assign hp_last = (hp_cnt_q == HP_LAST);

    always_comb begin
        state_d   = state_q;
        hp_cnt_d  = hp_cnt_q + 8'd1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sck_d     = sck_q;
        sdo_d     = sdo_q;
        cs_n_d    = cs_n_q;
        ready_d   = ready_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                hp_cnt_d  = '0;
                bit_cnt_d = '0;
                if (start && ready_q) begin
                    shift_d = frame;
                    sdo_d   = frame[23];
                    cs_n_d  = 1'b0;
                    ready_d = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (hp_last) begin
                    hp_cnt_d = '0;
                    sck_d    = 1'b1;
                    state_d  = SCK_HI;
                end
            end
            SCK_HI: begin
                // Data advances on the falling edge; zeros shift in behind,
                // so SDO is already 0 once the last bit has been clocked.
                if (hp_last) begin
                    hp_cnt_d  = '0;
                    sck_d     = 1'b0;
                    shift_d   = shift_q << 1;
                    sdo_d     = shift_q[22];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    state_d   = SCK_LO;
                end
            end
            SCK_LO: begin
                if (hp_last) begin
                    hp_cnt_d = '0;
                    if (bit_cnt_q == FRAME_BITS) begin
                        state_d = HOLD;
                    end else begin
                        sck_d   = 1'b1;
                        state_d = SCK_HI;
                    end
                end
            end
            HOLD: begin
                if (hp_last) begin
                    hp_cnt_d = '0;
                    cs_n_d   = 1'b1;
                    done_d   = 1'b1;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (hp_last) begin
                    hp_cnt_d = '0;
                    ready_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                hp_cnt_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q   <= IDLE;
            hp_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            sck_q     <= 1'b0;
            sdo_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hp_cnt_q  <= hp_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sck_q     <= sck_d;
            sdo_q     <= sdo_d;
            cs_n_q    <= cs_n_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign SCK   = sck_q;
    assign SDO   = sdo_q;
    assign CS_   = cs_n_q;

endmodule
